image_stream_loader: RTL

IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

---
 rtl/vec_mem_pkg.sv | 24 ++
 rtl/vec_addr_gen.sv | 42 ++++
 rtl/image_stream_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and default geometry for the image vector loader.
// One memory word carries NUM_LANES lanes, and each valid pixel sits zero-extended in the low PIX_W bits of a lane.
package vec_mem_pkg;

    localparam int DEF_IMAGE_WIDTH  = 96;
    localparam int DEF_IMAGE_HEIGHT = 96;
    localparam int DEF_PIX_PER_VEC  = 8;

    localparam int NUM_LANES = 16;
    localparam int LANE_W    = 16;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 16;
    localparam int IDX_W     = 11;

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vec_addr_gen.sv
// Pixel address and vector-count generator for the image loader.
// The address wraps modulo 2^ADDR_W, and o_last flags the final vector of the image.
module vec_addr_gen
    import vec_mem_pkg::*;
#(
    parameter int STEP    = DEF_PIX_PER_VEC,
    parameter int NUM_VEC = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT / DEF_PIX_PER_VEC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [IDX_W-1:0]  o_count,
    output logic              o_last
);

    localparam logic [IDX_W-1:0]  LAST_CNT  = IDX_W'(NUM_VEC - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STEP);

    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_addr  <= i_base;
            r_count <= '0;
        end else if (i_advance) begin
            r_addr  <= r_addr + ADDR_STEP;
            r_count <= r_count + IDX_W'(1);
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_last  = (r_count == LAST_CNT);

endmodule

// File: rtl/image_stream_loader.sv
// Streams one image from pixel memory as a sequence of masked vectors using a valid/ready handshake.
// Each vector takes one cycle to fetch and is then held until the consumer accepts it.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start
// ST_ISSUE | mem_addr valid, capture mem_rd at the next edge
// ST_HOLD  | vec_data presented, wait for vec_ready
// ST_DONE  | single-cycle done pulse
module image_stream_loader
    import vec_mem_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int PIX_PER_VEC  = DEF_PIX_PER_VEC
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] mem_rd,
    output logic [NUM_LANES-1:0][LANE_W-1:0] vec_data,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic [IDX_W-1:0]                 vec_index,
    output logic                             busy,
    output logic                             done
);

    localparam int NUM_VEC = IMAGE_WIDTH * IMAGE_HEIGHT / PIX_PER_VEC;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_capture;
    logic             w_accept;
    logic             w_advance;
    logic             w_last;
    logic [IDX_W-1:0] w_count;
    vec_t             w_masked;
    vec_t             r_vec_data;
    logic             r_vec_valid;
    logic [IDX_W-1:0] r_vec_index;
    logic             w_unused_rd;

    vec_addr_gen #(
        .STEP    (PIX_PER_VEC),
        .NUM_VEC (NUM_VEC)
    ) u_addr_gen (
        .CLK       (CLK),
        .RST       (RST),
        .i_load    (w_load),
        .i_base    (base_addr),
        .i_advance (w_advance),
        .o_addr    (mem_addr),
        .o_count   (w_count),
        .o_last    (w_last)
    );

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_capture = 1'b1;
                w_next    = ST_HOLD;
            end
            ST_HOLD: begin
                if (vec_ready) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_next = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = ST_ISSUE;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Only the low pixel byte of the first PIX_PER_VEC lanes is meaningful.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < PIX_PER_VEC; i++) begin
            w_masked[i][PIX_W-1:0] = mem_rd[i][PIX_W-1:0];
        end
    end

    assign w_unused_rd = ^mem_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_vec_data  <= '0;
            r_vec_valid <= 1'b0;
            r_vec_index <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_vec_data  <= w_masked;
                r_vec_valid <= 1'b1;
                r_vec_index <= w_count;
            end else if (w_accept) begin
                r_vec_valid <= 1'b0;
            end
        end
    end

    assign vec_data  = r_vec_data;
    assign vec_valid = r_vec_valid;
    assign vec_index = r_vec_index;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
